// File: rtl/barrel_shifter_pkg.sv
// Shared encodings for the pipelined barrel shifter.
// Used by the RTL and the testbench so both agree on the dir/op/shift_t meaning.
package barrel_shifter_pkg;

  // dir
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // op (only meaningful for right shifts)
  localparam logic OP_LOGIC  = 1'b0;
  localparam logic OP_ARITH  = 1'b1;

  // shift_t
  localparam logic SHT_SHIFT = 1'b0;
  localparam logic SHT_ROT   = 1'b1;

endpackage

// File: rtl/barrel_shifter_stage.sv
// One stage of the pipelined barrel shifter: conditionally shifts/rotates by 2**K and registers
// the result together with the operand's control bits, sticky flag and valid.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   up_*_i / up_ready_o  upstream side (operand + control entering this stage)
//   dn_*_o / dn_ready_i  downstream side (registered operand + control leaving this stage)
//
// Build option: BARREL_SHIFTER_PIPE_STICKY_EN adds a per-operand sticky register; without it
// dn_sticky_o is tied low and no sticky state exists.
module barrel_shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2W = 3,
  parameter int unsigned K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [W-1:0]     up_data_i,
  input  logic             up_dir_i,
  input  logic             up_op_i,
  input  logic             up_sht_i,
  input  logic [LOG2W-1:0] up_sel_i,
  input  logic             up_sticky_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [W-1:0]     dn_data_o,
  output logic             dn_dir_o,
  output logic             dn_op_o,
  output logic             dn_sht_o,
  output logic [LOG2W-1:0] dn_sel_o,
  output logic             dn_sticky_o
);

  localparam int unsigned Amt = 1 << K;
  localparam logic [W-1:0] AllOnes = {W{1'b1}};
  // Bits that fall off the bottom on a right shift / off the top on a left shift.
  localparam logic [W-1:0] LowMask  = ~(AllOnes << Amt);
  localparam logic [W-1:0] HighMask = ~(AllOnes >> Amt);

  logic             valid_q;
  logic [W-1:0]     data_q;
  logic             dir_q, op_q, sht_q;
  logic [LOG2W-1:0] sel_q;

  logic [W-1:0] shl, shr, fill, res;
  logic         disc;

  // Accept when empty or when the held operand leaves this cycle, so bubbles collapse.
  assign up_ready_o = !valid_q || dn_ready_i;

  always_comb begin
    shl  = up_data_i << Amt;
    shr  = up_data_i >> Amt;
    fill = (up_op_i == OP_ARITH && up_data_i[W-1]) ? HighMask : '0;
    res  = up_data_i;
    disc = 1'b0;
    if (up_sel_i[K]) begin
      if (up_sht_i == SHT_ROT) begin
        res = (up_dir_i == DIR_RIGHT) ? (shr | (up_data_i << (W - Amt)))
                                      : (shl | (up_data_i >> (W - Amt)));
      end else if (up_dir_i == DIR_RIGHT) begin
        res  = shr | fill;
        disc = |(up_data_i & LowMask);
      end else begin
        res  = shl;
        disc = |(up_data_i & HighMask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      op_q    <= 1'b0;
      sht_q   <= 1'b0;
      sel_q   <= '0;
    end else if (up_ready_o) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q <= res;
        dir_q  <= up_dir_i;
        op_q   <= up_op_i;
        sht_q  <= up_sht_i;
        sel_q  <= up_sel_i;
      end
    end
  end

`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (up_ready_o && up_valid_i) begin
      sticky_q <= up_sticky_i | disc;
    end
  end

  assign dn_sticky_o = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = up_sticky_i ^ disc;
  assign dn_sticky_o   = 1'b0;
`endif

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_dir_o   = dir_q;
  assign dn_op_o    = op_q;
  assign dn_sht_o   = sht_q;
  assign dn_sel_o   = sel_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready handshakes: LOG2W registered stages, stage k
// shifting or rotating by 2**k when sel[k] is set. Latency LOG2W, throughput 1/cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake
//   dir, op, shift_t, sel operation control (see barrel_shifter_pkg), shift amount
//   in                    operand
//   out_valid / out_ready result handshake
//   out, sticky           result, OR of discarded bits
//   occ                   operands currently in flight (0..LOG2W)
//
// Build option: BARREL_SHIFTER_PIPE_STICKY_EN enables sticky tracking; otherwise sticky = 0.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir,
  input  logic             op,
  input  logic             shift_t,
  input  logic [LOG2W-1:0] sel,
  input  logic [W-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             sticky,
  output logic [LOG2W:0]   occ
);

  if (W != (1 << LOG2W)) begin : g_bad_cfg
    $error("barrel_shifter_pipe: W must equal 2**LOG2W");
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    logic             up_valid, up_dir, up_op, up_sht, up_sticky, dn_ready;
    logic [W-1:0]     up_data;
    logic [LOG2W-1:0] up_sel;
    logic             ready, s_valid, s_dir, s_op, s_sht, s_sticky;
    logic [W-1:0]     s_data;
    logic [LOG2W-1:0] s_sel;

    if (k == 0) begin : g_first
      assign up_valid  = in_valid;
      assign up_data   = in;
      assign up_dir    = dir;
      assign up_op     = op;
      assign up_sht    = shift_t;
      assign up_sel    = sel;
      assign up_sticky = 1'b0;
    end else begin : g_chain
      assign up_valid  = g_stage[k-1].s_valid;
      assign up_data   = g_stage[k-1].s_data;
      assign up_dir    = g_stage[k-1].s_dir;
      assign up_op     = g_stage[k-1].s_op;
      assign up_sht    = g_stage[k-1].s_sht;
      assign up_sel    = g_stage[k-1].s_sel;
      assign up_sticky = g_stage[k-1].s_sticky;
    end

    if (k == LOG2W - 1) begin : g_last
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = g_stage[k+1].ready;
    end

    barrel_shifter_stage #(
      .W     (W),
      .LOG2W (LOG2W),
      .K     (k)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .up_valid_i  (up_valid),
      .up_ready_o  (ready),
      .up_data_i   (up_data),
      .up_dir_i    (up_dir),
      .up_op_i     (up_op),
      .up_sht_i    (up_sht),
      .up_sel_i    (up_sel),
      .up_sticky_i (up_sticky),
      .dn_valid_o  (s_valid),
      .dn_ready_i  (dn_ready),
      .dn_data_o   (s_data),
      .dn_dir_o    (s_dir),
      .dn_op_o     (s_op),
      .dn_sht_o    (s_sht),
      .dn_sel_o    (s_sel),
      .dn_sticky_o (s_sticky)
    );
  end

  assign in_ready  = g_stage[0].ready;
  assign out_valid = g_stage[LOG2W-1].s_valid;
  assign out       = g_stage[LOG2W-1].s_data;
  assign sticky    = g_stage[LOG2W-1].s_sticky;

  // Control bits are spent by the time the operand leaves the last stage.
  logic unused_ctrl;
  assign unused_ctrl = ^{g_stage[LOG2W-1].s_dir, g_stage[LOG2W-1].s_op,
                         g_stage[LOG2W-1].s_sht, g_stage[LOG2W-1].s_sel};

  logic [LOG2W:0] occ_q, occ_d;
  logic           accept, emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (accept && !emit) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && emit) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits.
REQ-002 SHALL have parameter LOG2W, default 3: shift-amount width; the block SHALL require W == 2**LOG2W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-007 SHALL have port dir, input, 1 bit: 0 = left, 1 = right.
REQ-008 SHALL have port op, input, 1 bit: 0 = logical, 1 = arithmetic (sign-fill on right shift only).
REQ-009 SHALL have port shift_t, input, 1 bit: 0 = shift, 1 = rotate.
REQ-010 SHALL have port sel, input, LOG2W bits: unsigned shift amount.
REQ-011 SHALL have port in, input, W bits: signed operand.
REQ-012 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port out, output, W bits: the shifted or rotated result.
REQ-015 SHALL have port sticky, output, 1 bit: OR of the bits discarded by the shift.
REQ-016 SHALL have port occ, output, LOG2W+1 bits: number of operands currently in flight.

Function
REQ-017 SHALL accept an operand on a cycle where in_valid && in_ready, and emit a result on a cycle where out_valid && out_ready.
REQ-018 SHALL implement LOG2W registered stages; stage k applies a shift or rotate by 2**k when sel[k] = 1, otherwise it passes the data through.
REQ-019 SHALL have a latency of exactly LOG2W cycles from acceptance to out_valid when there is no backpressure, and a throughput of 1 operand per cycle.
REQ-020 SHALL advance each stage when the downstream stage is empty or advancing in the same cycle, so that bubbles collapse.
REQ-021 SHALL compute in_ready combinationally as !stage0_valid || stage0_advances.
REQ-022 SHALL carry dir, op, shift_t and the remaining sel bits alongside the data, so that operands in flight are independent.
REQ-023 Left shift SHALL zero-fill, and op SHALL be ignored on left shifts.
REQ-024 Right logical shift SHALL zero-fill; right arithmetic shift SHALL replicate in[W-1].
REQ-025 Rotate SHALL be modulo W in the selected direction, and op SHALL be ignored on rotates.
REQ-026 When sel = 0, out SHALL equal in.
REQ-027 While out_valid = 1 and out_ready = 0, out, sticky and out_valid SHALL hold stable.
REQ-028 occ SHALL increment on accept only, decrement on emit only, and be unchanged when accept and emit happen in the same cycle; its range SHALL be 0 to LOG2W.
REQ-029 The pipeline SHALL preserve order; no operand is dropped or duplicated.

Reset
REQ-030 While rst = 1, all stage valids SHALL clear at the next edge, so that out_valid = 0 and occ = 0.
REQ-031 While rst = 1, out, sticky and the stage data SHALL reset to 0.
REQ-032 Operands in flight when rst asserts SHALL be discarded and never emitted.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-034 With BARREL_SHIFTER_PIPE_STICKY_EN defined, each stage SHALL OR the bits it discards into a per-operand sticky flag, for non-rotate shifts in either direction; rotates SHALL give sticky = 0.
REQ-035 Without BARREL_SHIFTER_PIPE_STICKY_EN, the sticky port SHALL remain present but be tied to 0, and no sticky registers SHALL be synthesised.

Structure
REQ-036 The encodings DIR_LEFT/DIR_RIGHT, OP_LOGIC/OP_ARITH and SHT_SHIFT/SHT_ROT SHALL live in the shared header barrel_shifter_pkg, which is also used by the bench.
REQ-037 A single sub-module, barrel_shifter_stage, parametrised by stage index K, SHALL hold one shift-by-2**K mux, its data/control/sticky/valid registers and its advance logic; the top SHALL instantiate it LOG2W times.

Verification (W = 8, LOG2W = 3)
REQ-038 SHALL cover a right arithmetic shift: in = 8'h96, dir = 1, op = 1, shift_t = 0, sel = 3 -> out = 8'hF2 and sticky = 1, exactly 3 cycles after acceptance.
REQ-039 SHALL cover the shift and rotate edges: rotate left of 8'h81 by 1 -> 8'h03 with sticky = 0; logical left of 8'h01 by 7 -> 8'h80; logical right of 8'h80 by 7 -> 8'h01 with sticky = 0.
REQ-040 SHALL cover streaming: 16 back-to-back random operands with out_ready held at 1 -> 16 consecutive results in order matching the reference model, with in_ready held at 1 and occ = 3 in steady state.
REQ-041 SHALL cover backpressure: out_ready = 0 while pushing -> exactly 3 operands accepted, then in_ready = 0 and occ = 3 with out stable; releasing out_ready -> 3 results drained in order and occ = 0.
REQ-042 SHALL cover reset mid-operation: rst for 1 cycle after 2 accepts -> occ = 0 and out_valid = 0 on the next cycle, and no stale result appears afterwards.
REQ-043 SHALL cover the macro-off build: the REQ-038 stimulus with BARREL_SHIFTER_PIPE_STICKY_EN undefined -> out = 8'hF2 and sticky = 0.
